vga_scan_timing: RTL



---
 rtl/vga_scan_timing.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// vga_scan_timing
//   Raster scan generator for a 640x480@60 Hz VGA output. It produces the
//   pixel coordinates consumed by the object renderer, and a per-frame tick
//   for the game logic. It re-times the sync and blanking terms so that they
//   leave the block on the same clk as the renderer's colour for that pixel.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   pixel_x       current horizontal count, 0..H_TOTAL-1
//   pixel_y       current vertical count, 0..V_TOTAL-1
//   pixel_tick    one-clk pulse; the counters advance on the following edge
//   frame_tick    one-clk pulse on the first clk of (0, V_DISPLAY)
//   object_on     renderer hit flag, RENDER_LAT clk after the coordinate
//   object_color  renderer colour {R,G,B}, same timing as object_on
//   hsync, vsync  VGA sync pins, pulse level = SYNC_ACTIVE
//   video_on      visible-area flag, aligned with rgb
//   rgb           VGA colour {R,G,B}, black outside the visible area
module vga_scan_timing #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_DIV     = 2,
  parameter int RENDER_LAT  = 5,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_tick,
  output logic       frame_tick,
  input  logic       object_on,
  input  logic [2:0] object_color,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  // PIX_DIV is at most 8, so a 3-bit divider covers every legal setting.
  localparam logic [2:0] DIV_LAST = 3'(PIX_DIV - 1);

  logic [2:0] div_cnt;
  logic [2:0] div_nxt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic       von_raw;
  logic       hs_d;
  logic       vs_d;
  logic       von_d;

  // Each stage holds {hs, vs, von}; stage 0 is one clk behind the counters.
  logic [2:0] align_dly [RENDER_LAT];

  // ---------------------------------------------------------------------
  // Pixel divider. pixel_tick is registered from the next divider value so
  // that it is high exactly while div_cnt sits at its last count.
  // ---------------------------------------------------------------------
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 3'd0 : div_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= 3'd0;
      pixel_tick <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      pixel_tick <= (div_nxt == DIV_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pixel_tick) begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  // Fires on the edge that moves the scan onto (0, V_DISPLAY), so the pulse
  // covers the first clk of that coordinate and nothing else.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pixel_tick && h_wrap && (v_cnt == V_VIS_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Raw timing decode and alignment to the renderer latency
  // ---------------------------------------------------------------------
  always_comb begin
    hs_raw  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_raw  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    von_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Runs every clk rather than on pixel_tick: the renderer latency is counted
  // in clk, so the last stage lines up with object_on/object_color for the
  // coordinate that produced it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RENDER_LAT; i++) begin
        align_dly[i] <= 3'b000;
      end
    end else begin
      align_dly[0] <= {hs_raw, vs_raw, von_raw};
      for (int i = 1; i < RENDER_LAT; i++) begin
        align_dly[i] <= align_dly[i-1];
      end
    end
  end

  assign {hs_d, vs_d, von_d} = align_dly[RENDER_LAT-1];

  // ---------------------------------------------------------------------
  // Output register. Colour is gated by the delayed visible flag so blanking
  // is always black whatever the renderer reports.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      video_on <= 1'b0;
      rgb      <= 3'b000;
    end else begin
      hsync    <= hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= vs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on <= von_d;
      rgb      <= (von_d && object_on) ? object_color : 3'b000;
    end
  end

endmodule
